// File: rtl/sail_hex_pkg.sv
// Shared types, character constants and helpers for the Sail hex-literal parser.
package sail_hex_pkg;

  typedef enum logic [2:0] {
    ST_P0    = 3'd0,  // expect '0'
    ST_PX    = 3'd1,  // expect lowercase 'x'
    ST_LEAD  = 3'd2,  // skipping leading zero digits
    ST_DIG   = 3'd3,  // past the first non-zero digit
    ST_DRAIN = 3'd4,  // error seen, discarding up to in_last
    ST_DONE  = 3'd5   // result held on the output
  } state_e;

  localparam logic [7:0] CH_0  = 8'h30;  // '0'
  localparam logic [7:0] CH_X  = 8'h78;  // 'x'
  localparam logic [7:0] CH_9  = 8'h39;  // '9'
  localparam logic [7:0] CH_UA = 8'h41;  // 'A'
  localparam logic [7:0] CH_UF = 8'h46;  // 'F'
  localparam logic [7:0] CH_LA = 8'h61;  // 'a'
  localparam logic [7:0] CH_LF = 8'h66;  // 'f'

  // Significant bit count of the first non-zero digit (0 for a zero digit).
  function automatic logic [2:0] sail_hex_fnz_width(input logic [3:0] digit);
    if (digit == 4'd0)       return 3'd0;
    else if (digit == 4'd1)  return 3'd1;
    else if (digit <= 4'd3)  return 3'd2;
    else if (digit <= 4'd7)  return 3'd3;
    else                     return 3'd4;
  endfunction

endpackage

// File: rtl/sail_hex_digit.sv
// Combinational ASCII hex digit decoder; digit case is not significant.
module sail_hex_digit
  import sail_hex_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_hex,
  output logic [3:0] value
);

  // Classify the character and produce its nibble value.
  always_comb begin
    is_hex = 1'b0;
    value  = 4'd0;
    if (in_char >= CH_0 && in_char <= CH_9) begin
      is_hex = 1'b1;
      value  = 4'(in_char - CH_0);
    end else if (in_char >= CH_UA && in_char <= CH_UF) begin
      is_hex = 1'b1;
      value  = 4'(in_char - CH_UA + 8'd10);
    end else if (in_char >= CH_LA && in_char <= CH_LF) begin
      is_hex = 1'b1;
      value  = 4'(in_char - CH_LA + 8'd10);
    end
  end

endmodule

// File: rtl/sail_hex_parser.sv
// Byte-serial "0x..." hex literal parser producing an N-bit value and a fit/valid flag.
module sail_hex_parser
  import sail_hex_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_char,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ok,
  output logic [N-1:0] out_bits
);

  // Width counter saturates at N+1: anything past N is simply "too wide".
  localparam int WW = $clog2(N + 2);
  localparam logic [WW:0] W_SAT_X = (WW + 1)'(N + 1);
  localparam logic [WW:0] W_MAX_X = (WW + 1)'(N);

  state_e        state, state_nxt;
  logic [N-1:0]  acc, acc_nxt;
  logic [WW-1:0] width, width_nxt;
  logic          err, err_nxt;
  logic          ok_nxt;
  logic          beat;
  logic          is_hex;
  logic [3:0]    dval;
  logic [WW:0]   w_add, w_fnz;

  sail_hex_digit u_digit (
    .in_char (in_char),
    .is_hex  (is_hex),
    .value   (dval)
  );

  assign out_valid = (state == ST_DONE);
  assign in_ready  = !rst && !out_valid;
  assign beat      = in_valid && in_ready;

  // Next state, accumulator, width and sticky error for the current beat.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    width_nxt = width;
    err_nxt   = err;
    w_add     = {1'b0, width} + (WW + 1)'(4);
    w_fnz     = (WW + 1)'(sail_hex_fnz_width(dval));
    if (state == ST_DONE) begin
      if (out_ready) begin
        // Entering P0 starts a fresh string.
        state_nxt = ST_P0;
        acc_nxt   = '0;
        width_nxt = '0;
        err_nxt   = 1'b0;
      end
    end else if (beat) begin
      unique case (state)
        ST_P0: begin
          if (in_char == CH_0) state_nxt = ST_PX;
          else begin
            err_nxt   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
        ST_PX: begin
          if (in_char == CH_X) state_nxt = ST_LEAD;
          else begin
            err_nxt   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
        ST_LEAD, ST_DIG: begin
          if (!is_hex) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            acc_nxt = N'({acc, dval});
            if (state == ST_DIG) begin
              width_nxt = (w_add > W_SAT_X) ? W_SAT_X[WW-1:0] : w_add[WW-1:0];
            end else if (dval != 4'd0) begin
              width_nxt = (w_fnz > W_SAT_X) ? W_SAT_X[WW-1:0] : w_fnz[WW-1:0];
              state_nxt = ST_DIG;
            end
          end
        end
        default: ;  // DRAIN swallows characters until in_last
      endcase
      if (in_last) begin
        // A string ending during the prefix is too short to be a literal.
        if (state == ST_P0 || state == ST_PX) err_nxt = 1'b1;
        state_nxt = ST_DONE;
      end
    end
    ok_nxt = !err_nxt && ({1'b0, width_nxt} <= W_MAX_X);
  end

  // State and datapath registers; the result is latched on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_P0;
      acc      <= '0;
      width    <= '0;
      err      <= 1'b0;
      out_ok   <= 1'b0;
      out_bits <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      width <= width_nxt;
      err   <= err_nxt;
      if (beat && in_last) begin
        out_ok   <= ok_nxt;
        out_bits <= ok_nxt ? acc_nxt : '0;
      end else if (state == ST_DONE && out_ready) begin
        out_ok   <= 1'b0;
        out_bits <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sail_hex_parser.sv
// Randomized + directed bench: four widths run in lockstep against a string-level model.
module tb_sail_hex_parser;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, out_ready;
  logic [7:0]    in_char;
  logic [ND-1:0] in_ready, out_valid, out_ok;
  logic [7:0]    b8;
  logic [8:0]    b9;
  logic [15:0]   b16;
  logic [31:0]   b32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sail_hex_parser #(.N(8)) u_n8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .out_ok(out_ok[0]), .out_bits(b8));
  sail_hex_parser #(.N(9)) u_n9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .out_ok(out_ok[1]), .out_bits(b9));
  sail_hex_parser #(.N(16)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready), .out_ok(out_ok[2]), .out_bits(b16));
  sail_hex_parser #(.N(32)) u_n32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid[3]), .out_ready(out_ready), .out_ok(out_ok[3]), .out_bits(b32));

  function automatic int nw(input int d);
    case (d)
      0:       return 8;
      1:       return 9;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [63:0] bits_of(input int d);
    case (d)
      0:       return 64'(b8);
      1:       return 64'(b9);
      2:       return 64'(b16);
      default: return 64'(b32);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int hexval(input byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: literal is valid if it is "0x" + >=1 hex digit, and its
  // significant bit count (leading zeros stripped) fits in n bits.
  function automatic void model(input string s, input int n, output bit ok, output logic [63:0] val);
    int k, w, d, bl;
    logic [63:0] v;
    ok = 1'b0;
    val = '0;
    if (s.len() < 3) return;
    if (s[0] != 8'h30 || s[1] != 8'h78) return;
    k = 0; w = 0; v = '0;
    for (int i = 2; i < s.len(); i++) begin
      d = hexval(s[i]);
      if (d < 0) return;
      if (k == 0 && d == 0) continue;
      if (k == 0) begin
        bl = 0;
        while ((d >> bl) != 0) bl++;
        w = bl;
      end else begin
        w += 4;
      end
      k++;
      v = (v << 4) | 64'(d);
    end
    ok = (w <= n);
    if (ok) val = v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(in_ready), 64'hF);
  endtask

  // Stream a string; called and returns at a negedge.
  task automatic send_str(input string s, input bit gaps, input bit term);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_char  = 8'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_char  = s[i];
      in_last  = term && (i == s.len() - 1);
      wait_ready();
      @(negedge clk);
      if (!(term && i == s.len() - 1)) chk("no_early_valid", 64'(out_valid), 64'h0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the held result for hold+1 cycles, then handshake.
  task automatic recv(input string s, input int hold, input bit pres_next);
    bit eo;
    logic [63:0] ev;
    if (pres_next) begin
      in_valid = 1'b1;
      in_char  = 8'h30;
      in_last  = 1'b0;
    end
    for (int i = 0; i <= hold; i++) begin
      for (int d = 0; d < ND; d++) begin
        model(s, nw(d), eo, ev);
        chk($sformatf("%s N%0d ok c%0d", s, nw(d), i), 64'(out_ok[d]), 64'(eo));
        chk($sformatf("%s N%0d bits c%0d", s, nw(d), i), bits_of(d), ev);
      end
      chk($sformatf("%s valid c%0d", s, i), 64'(out_valid), 64'hF);
      chk($sformatf("%s in_ready_done c%0d", s, i), 64'(in_ready), 64'h0);
      out_ready = (i == hold);
      @(negedge clk);
    end
    chk($sformatf("%s valid_drop", s), 64'(out_valid), 64'h0);
    chk($sformatf("%s in_ready_back", s), 64'(in_ready), 64'hF);
  endtask

  task automatic run(input string s, input bit gaps, input int hold, input bit pres_next);
    send_str(s, gaps, 1'b1);
    recv(s, hold, pres_next);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " valid"}, 64'(out_valid), 64'h0);
    chk({tag, " ok"}, 64'(out_ok), 64'h0);
    chk({tag, " bits"}, 64'(b32) | 64'(b16) | 64'(b9) | 64'(b8), 64'h0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'h0);
  endtask

  function automatic string rand_str();
    string hx = "0123456789abcdefABCDEF";
    string s;
    int r = $urandom_range(9);
    case (r)
      0: s = "0X";
      1: s = "1x";
      2: s = "x0";
      3: return ($urandom_range(1) == 0) ? "0" : "0x";
      default: s = "0x";
    endcase
    for (int i = $urandom_range(3); i > 0; i--) s = {s, "0"};
    for (int i = $urandom_range(1, 9); i > 0; i--) begin
      if ($urandom_range(24) == 0) s = {s, "g"};
      else s = $sformatf("%s%c", s, hx[$urandom_range(21)]);
    end
    return s;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_cleared("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'hF);

    run("0x1F", 1'b0, 0, 1'b0);
    run("0x100", 1'b0, 0, 1'b0);
    run("0x000000FF", 1'b0, 1, 1'b0);
    run("0x0", 1'b0, 0, 1'b0);
    run("0xg1", 1'b0, 0, 1'b0);
    run("0x", 1'b0, 0, 1'b0);
    run("0X12", 1'b0, 0, 1'b0);
    run("1x12", 1'b0, 0, 1'b0);
    run("0", 1'b0, 0, 1'b0);
    run("0x3", 1'b0, 3, 1'b1);
    run("0x1ffff", 1'b0, 0, 1'b0);
    run("0xDeadBeef", 1'b1, 2, 1'b0);
    run("0x123456789", 1'b0, 0, 1'b0);

    // Reset mid-string discards the partial literal.
    send_str("0x12", 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_cleared("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("0xAB", 1'b0, 0, 1'b0);

    // Reset while a result is held clears it at once.
    send_str("0x3F", 1'b0, 1'b1);
    chk("pre_rst_valid", 64'(out_valid), 64'hF);
    #2 rst = 1'b1;
    #1 chk_cleared("rst_done");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 60; t++) begin
      run(rand_str(), 1'($urandom), $urandom_range(3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sail_hex_parser.md
# sail_hex_parser

Byte-serial, synthesizable parser that turns a Sail hex-literal character stream ("0x…") into an N-bit bitvector plus a validity flag. It sits directly upstream of any bitvector consumer in generated Sail RTL. It applies the same acceptance rule as the library's combinational hex validity check, but one character per cycle over a valid/ready stream, so long literals need no wide string hardware.

## Interface
- N, default 64: result width in bits; N >= 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  character beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_char  input  8  ASCII character.
- in_last  input  1  beat is the final character of the string.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_ok  output  1  string is a valid hex literal that fits in N bits.
- out_bits  output  N  parsed value; all zero when out_ok = 0.

## Operation
- A beat is accepted when in_valid && in_ready. in_ready = !rst && !out_valid.
- FSM states:
  - P0: expect '0'.
  - PX: expect 'x' (lowercase only).
  - LEAD: skipping leading '0'.
  - DIG: past the first non-zero digit.
  - DRAIN: error seen, discard to in_last.
  - DONE: out_valid high.
- Sticky err flag is cleared on entry to P0.
- P0: '0' → PX. Any other character sets err → DRAIN.
- PX: 'x' → LEAD. Any other character sets err → DRAIN.
- in_last on the P0 or PX beat sets err; covers strings shorter than 3 characters, including "0x".
- LEAD handling:
  - '0' stays in LEAD with width = 0.
  - A valid non-zero hex digit sets width by its value: '1' → 1; '2'–'3' → 2; '4'–'7' → 3; '8'–'9', 'A'–'F', 'a'–'f' → 4. Then → DIG.
- DIG: each valid digit adds 4 to width. The width counter saturates at N+1; its size is clog2(N+2) bits.
- In LEAD or DIG, any character that is not 0-9/A-F/a-f sets err → DRAIN.
- Accumulator: acc <= (acc << 4) | digit, truncated to N bits. It clears on P0 entry.
- On the in_last beat in any state:
  - out_ok = !err && (width <= N), including the in_last character itself.
  - out_bits = out_ok ? acc_final : 0.
  - Next state is DONE.
- DONE: hold out_valid, out_ok and out_bits stable until out_ready. Then → P0 and out_valid drops.
- Digit values are case-insensitive. The prefix 'x' is case-sensitive; "0X…" is invalid.

## Timing
- Reset values: out_valid 0, out_ok 0, out_bits 0, FSM P0, acc 0, width 0, err 0. in_ready is 0 while rst is high.
- Throughput: one character per cycle while not in DONE.
- Latency: out_valid rises on the first clock edge after the in_last beat is accepted.
- Result handshake:
  - In DONE, in_ready = 0. No beat is accepted in the same cycle as the out_ready handshake.
  - The next string's first beat can be accepted on the cycle after the handshake, so there is 1 idle cycle per string.
- in_valid with out_valid high: the beat is not consumed, and the source must hold it.
- rst asserted mid-string or in DONE: immediately returns to reset values. A partial string is discarded with no output. The source restarts the string after reset.
- There is no timeout; an unterminated string stays in its current state indefinitely.

## Structure
- Shared package sail_hex_pkg contains:
  - The state enum.
  - Character constants ('0', 'x', '9', 'A', 'F', 'a', 'f').
  - Function sail_hex_fnz_width(digit) → 0..4.
- Sub-module sail_hex_digit (combinational): in_char → is_hex, value[3:0].
- All sequential logic lives in sail_hex_parser.

## Test plan
- N=8, "0x1F" streamed back-to-back, out_ready=1 → out_valid 1 cycle after the 'F' beat; out_ok=1, out_bits=8'h1F.
- N=8, "0x100" → out_ok=0, out_bits=0 (width 9 > 8). Same string with N=9 → out_ok=1, 9'h100.
- N=8, "0x000000FF" → out_ok=1, 8'hFF (leading zeros ignored). "0x0" → out_ok=1, 0.
- N=16:
  - "0xg1" → out_ok=0. The remaining beats are still accepted; out_valid appears only after in_last.
  - "0x" → out_ok=0.
  - "0X12" → out_ok=0.
  - "1x12" → out_ok=0.
- N=8, "0x3", out_ready held low 3 cycles with the next string's '0' presented:
  - in_ready stays 0 and the outputs stay stable (ok=1, bits=3).
  - The '0' is accepted the cycle after the handshake.
- N=32, rst pulsed asynchronously after "0x12": outputs return to 0 immediately. A following "0xAB" → out_ok=1, 32'hAB.
